// File: rtl/rv_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_mem_pkg
// Description : Shared types for the data-memory responder: word width,
//               responder FSM states and decoded request opcodes.
// Revision    : 1.0 - initial release
// ============================================================================
package rv_mem_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  typedef enum logic [1:0] {
    OP_NONE    = 2'd0,
    OP_LOAD    = 2'd1,
    OP_STORE   = 2'd2,
    OP_ILLEGAL = 2'd3
  } dmem_op_t;

  // Both strobes high at once is a decode fault, not a read-modify-write.
  function automatic dmem_op_t decode_op(input logic i_rd, input logic i_wr);
    dmem_op_t v_op;
    case ({i_rd, i_wr})
      2'b10:   v_op = OP_LOAD;
      2'b01:   v_op = OP_STORE;
      2'b11:   v_op = OP_ILLEGAL;
      default: v_op = OP_NONE;
    endcase
    return v_op;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// Module      : dmem_array
// Description : Single-port synchronous RAM, DEPTH x WORD_W. Read data is
//               registered and only updates on an enabled read, so it holds
//               between accesses. Storage is never reset.
// Ports       : clk      - clock
//               i_en     - access enable (read or write this edge)
//               i_we     - write enable (qualified by i_en)
//               i_idx    - word index
//               i_wdata  - write data
//               o_rdata  - registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_array
  import rv_mem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [WORD_W-1:0] i_wdata,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] r_mem [0:DEPTH-1];
  logic [WORD_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        r_mem[i_idx] <= i_wdata;
      end else begin
        r_rdata <= r_mem[i_idx];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Data-memory responder for pipeline load/store requests.
//               Accepts one word access at a time, inserts WAIT_CYCLES wait
//               states, performs the RAM access in RESP and pulses done (with
//               err on rejection) the following cycle.
//               Optional feature macro: DMEM_MISALIGN_TRAP_EN - when defined,
//               addr[1:0] != 0 rejects the access; otherwise the low address
//               bits are ignored.
// Ports       : clk, rst     - clock, asynchronous active-high reset
//               i_mem_read   - load request
//               i_mem_write  - store request
//               i_addr       - byte address
//               i_wdata      - store data
//               o_rdata      - load data, valid with done, held until next done
//               o_done       - one-cycle completion pulse
//               o_err        - one-cycle rejection pulse (with done)
//               o_busy       - pipeline stall; requests ignored while high
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
  import rv_mem_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic [WORD_W-1:0] i_addr,
  input  logic [WORD_W-1:0] i_wdata,
  output logic [WORD_W-1:0] o_rdata,
  output logic              o_done,
  output logic              o_err,
  output logic              o_busy
);

  localparam int         IDX_W       = $clog2(DEPTH);
  localparam logic [3:0] c_WAIT_LOAD = 4'(WAIT_CYCLES);

  dmem_state_t       r_state, w_next_state;
  logic [3:0]        r_cnt, w_cnt_next;
  logic              w_accept;
  logic [WORD_W-1:2] r_addr;
  logic [WORD_W-1:0] r_wdata;
  dmem_op_t          r_op;
  logic              r_done, r_err, r_rd_valid;
  logic              w_oor, w_misalign, w_reject;
  logic              w_ram_en, w_ram_we;
  logic [WORD_W-1:0] w_ram_rdata;

  // -------------------------------------------------------------- FSM state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = r_cnt;
    w_accept     = 1'b0;
    o_busy       = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_mem_read || i_mem_write) begin
          w_accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            w_next_state = RESP;
          end else begin
            w_next_state = WAIT;
            w_cnt_next   = c_WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        o_busy     = 1'b1;
        w_cnt_next = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_next_state = RESP;
        end
      end
      RESP: begin
        o_busy       = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // ------------------------------------------------------- request latches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_op    <= OP_NONE;
    end else if (w_accept) begin
      r_addr  <= i_addr[WORD_W-1:2];
      r_wdata <= i_wdata;
      r_op    <= decode_op(i_mem_read, i_mem_write);
    end
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  logic r_misalign;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_misalign <= 1'b0;
    end else if (w_accept) begin
      r_misalign <= |i_addr[1:0];
    end
  end
  assign w_misalign = r_misalign;
`else
  // Low address bits are deliberately ignored: access uses the aligned word.
  logic w_unused_addr_lo;
  assign w_unused_addr_lo = ^i_addr[1:0];
  assign w_misalign       = 1'b0;
`endif

  // -------------------------------------------------------- access checks
  assign w_oor    = |r_addr[WORD_W-1:IDX_W+2];
  assign w_reject = (r_op == OP_ILLEGAL) || w_oor || w_misalign;
  // RAM is touched only on the RESP edge and only for a legal access, so a
  // reset during WAIT can never commit a store.
  assign w_ram_en = (r_state == RESP) && !w_reject;
  assign w_ram_we = w_ram_en && (r_op == OP_STORE);

  dmem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk     (clk),
    .i_en    (w_ram_en),
    .i_we    (w_ram_we),
    .i_idx   (r_addr[IDX_W+1:2]),
    .i_wdata (r_wdata),
    .o_rdata (w_ram_rdata)
  );

  // ------------------------------------------------------ completion flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_rd_valid <= 1'b0;
    end else if (r_state == RESP) begin
      r_done     <= 1'b1;
      r_err      <= w_reject;
      r_rd_valid <= (r_op == OP_LOAD) && !w_reject;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end
  end

  // The RAM output register is not reset; r_rd_valid masks it so reset and
  // rejected/store completions present zero, and it holds until next done.
  assign o_rdata = r_rd_valid ? w_ram_rdata : '0;
  assign o_done  = r_done;
  assign o_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Self-checking bench for dmem_responder. A reference memory
//               model produces expected completions that are queued at
//               request time and compared when done arrives.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

  localparam int DEPTH = 256;
  localparam int W     = 1;
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    logic        chk_rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata;
  logic        done, err, busy;

  logic        z_mem_read = 1'b0, z_mem_write = 1'b0;
  logic [31:0] z_addr = '0, z_wdata = '0;
  logic [31:0] z_rdata;
  logic        z_done, z_err, z_busy;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] model [DEPTH];
  exp_t        sb [$];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .i_mem_read(mem_read), .i_mem_write(mem_write),
    .i_addr(addr), .i_wdata(wdata), .o_rdata(rdata), .o_done(done),
    .o_err(err), .o_busy(busy)
  );

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut_z (
    .clk(clk), .rst(rst), .i_mem_read(z_mem_read), .i_mem_write(z_mem_write),
    .i_addr(z_addr), .i_wdata(z_wdata), .o_rdata(z_rdata), .o_done(z_done),
    .o_err(z_err), .o_busy(z_busy)
  );

  function automatic logic rejects(input logic rd, input logic wr,
                                   input logic [31:0] a);
    return (rd & wr) || (a[31:10] != 22'd0) || (TRAP && (a[1:0] != 2'd0));
  endfunction

  // Entered away from a clock edge with the DUT idle (or in its done cycle).
  // Leaves at the negedge of the done cycle so a following call is issued
  // back-to-back.
  task automatic do_access(input logic rd, input logic wr,
                           input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    int   lat;
    bit   got;
    e.err       = rejects(rd, wr, a);
    e.rdata     = (rd && !e.err) ? model[a[9:2]] : 32'd0;
    e.chk_rdata = rd;
    if (wr && !rd && !e.err) model[a[9:2]] = wd;
    sb.push_back(e);
    mem_read = rd; mem_write = wr; addr = a; wdata = wd;
    @(posedge clk);
    #1;
    mem_read = 1'b0; mem_write = 1'b0;
    addr = $urandom; wdata = $urandom;
    lat = 0; got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (done === 1'b1) begin
        got = 1'b1;
      end else begin
        vectors++;
        if (busy !== 1'b1) begin
          miscompares++;
          $display("FAIL busy_wait a=%h cyc=%0d busy=%b required=1", a, lat, busy);
        end
      end
    end
    e = sb.pop_front();
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL done_timeout a=%h no done within %0d cycles", a, lat);
    end else begin
      if (lat !== 2 + W) begin
        miscompares++;
        $display("FAIL latency a=%h got=%0d required=%0d", a, lat, 2 + W);
      end
      vectors++;
      if (err !== e.err) begin
        miscompares++;
        $display("FAIL err a=%h got=%b required=%b", a, err, e.err);
      end
      vectors++;
      if (busy !== 1'b0) begin
        miscompares++;
        $display("FAIL busy_done a=%h got=%b required=0", a, busy);
      end
      if (e.chk_rdata) begin
        vectors++;
        if (rdata !== e.rdata) begin
          miscompares++;
          $display("FAIL rdata a=%h got=%h required=%h", a, rdata, e.rdata);
        end
      end
    end
  endtask

  task automatic test_reset();
    #12;
    vectors++;
    if ({rdata, done, err, busy} !== 35'd0) begin
      miscompares++;
      $display("FAIL reset_w1 got rdata=%h done=%b err=%b busy=%b required all 0",
               rdata, done, err, busy);
    end
    vectors++;
    if ({z_rdata, z_done, z_err, z_busy} !== 35'd0) begin
      miscompares++;
      $display("FAIL reset_w0 got rdata=%h done=%b err=%b busy=%b required all 0",
               z_rdata, z_done, z_err, z_busy);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      do_access(1'b0, 1'b1, 32'(i * 4), $urandom);
    end
    @(negedge clk);
  endtask

  task automatic test_store_load();
    do_access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    @(negedge clk);
    do_access(1'b1, 1'b0, 32'h10, 32'h0);
    vectors++;
    if (rdata !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL load_10 got=%h required=deadbeef", rdata);
    end
    @(negedge clk);
    vectors++;
    if (rdata !== 32'hDEADBEEF || done !== 1'b0) begin
      miscompares++;
      $display("FAIL rdata_hold got=%h done=%b required=deadbeef/0", rdata, done);
    end
  endtask

  task automatic test_zero_wait();
    for (int i = 0; i < 2; i++) begin
      z_mem_write = (i == 0); z_mem_read = (i == 1);
      z_addr = 32'h40; z_wdata = 32'h12345678;
      @(posedge clk);
      #1;
      z_mem_write = 1'b0; z_mem_read = 1'b0; z_addr = '0; z_wdata = '0;
      @(negedge clk);
      vectors++;
      if (z_busy !== 1'b1 || z_done !== 1'b0) begin
        miscompares++;
        $display("FAIL w0_cyc1 op=%0d busy=%b done=%b required busy=1 done=0",
                 i, z_busy, z_done);
      end
      @(negedge clk);
      vectors++;
      if (z_done !== 1'b1 || z_busy !== 1'b0 || z_err !== 1'b0) begin
        miscompares++;
        $display("FAIL w0_cyc2 op=%0d done=%b busy=%b err=%b required 1/0/0",
                 i, z_done, z_busy, z_err);
      end
      if (i == 1) begin
        vectors++;
        if (z_rdata !== 32'h12345678) begin
          miscompares++;
          $display("FAIL w0_rdata got=%h required=12345678", z_rdata);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_illegal();
    do_access(1'b0, 1'b1, 32'h20, 32'hCAFEF00D);
    @(negedge clk);
    do_access(1'b1, 1'b1, 32'h20, 32'h0BAD0BAD);
    @(negedge clk);
    do_access(1'b1, 1'b0, 32'h20, 32'h0);
    vectors++;
    if (rdata !== 32'hCAFEF00D) begin
      miscompares++;
      $display("FAIL illegal_kept got=%h required=cafef00d", rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_out_of_range();
    do_access(1'b1, 1'b0, 32'h400, 32'h0);
    @(negedge clk);
    do_access(1'b0, 1'b1, 32'h400, 32'hFFFFFFFF);
    @(negedge clk);
    for (int i = 0; i < DEPTH; i++) begin
      do_access(1'b1, 1'b0, 32'(i * 4), 32'h0);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    do_access(1'b0, 1'b1, 32'h8, 32'h11111111);
    @(negedge clk);
    do_access(1'b1, 1'b0, 32'h8, 32'h0);
    @(negedge clk);
    mem_write = 1'b1; addr = 32'h8; wdata = 32'h55;
    @(posedge clk);
    #1;
    mem_write = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if ({rdata, done, err, busy} !== 35'd0) begin
      miscompares++;
      $display("FAIL mid_reset rdata=%h done=%b err=%b busy=%b required all 0",
               rdata, done, err, busy);
    end
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset done=%b busy=%b required 0/0", done, busy);
    end
    do_access(1'b1, 1'b0, 32'h8, 32'h0);
    @(negedge clk);
  endtask

  task automatic test_misalign_back_to_back();
    do_access(1'b0, 1'b1, 32'h13, 32'hA5A5A5A5);
    do_access(1'b1, 1'b0, 32'h10, 32'h0);
    vectors++;
    if (rdata !== (TRAP ? 32'hDEADBEEF : 32'hA5A5A5A5)) begin
      miscompares++;
      $display("FAIL misalign_word got=%h required=%h", rdata,
               TRAP ? 32'hDEADBEEF : 32'hA5A5A5A5);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_fill();
    test_store_load();
    test_zero_wait();
    test_illegal();
    test_out_of_range();
    test_reset_mid_op();
    test_misalign_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
